// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch queue: ibus request/response, FIFO entry format,
// fetch FSM states, the reset PC and a saturating adder used by the optional stats.
package fetch_queue_pkg;

  localparam logic [63:0] FETCH_RESET_PC = 64'h8000_0000;

  typedef enum logic [1:0] {
    NOERROR        = 2'd0,
    INSTR_MISALIGN = 2'd1
  } fetch_error_t;

  typedef struct packed {
    logic         valid;
    logic [31:0]  instr;
    logic [63:0]  pc;
    fetch_error_t error;
  } fetch_data_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic        data_ok;
  } ibus_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b);
    logic [64:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[64] ? '1 : sum[63:0];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Generic DEPTH-entry FIFO of fetch_data_t with synchronous clear; the head is a
// combinational view of the oldest entry. DEPTH must be a power of two.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  fetch_data_t              din,
  input  logic                     pop,
  output fetch_data_t              head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  fetch_data_t    mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL_COUNT) || do_pop);
  assign head    = mem[rd_ptr];

  // Storage has no reset; only the pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Sequential-PC fetch stage with one outstanding ibus request and a DEPTH-entry
// instruction FIFO. Optional counters are enabled with the FETCH_STATS_EN macro.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH       = 4,
  parameter logic [63:0] RESET_PC    = FETCH_RESET_PC,
  parameter int          INSTR_BYTES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flushall,
  input  logic [63:0] csrpc,
  input  logic        branch,
  input  logic [63:0] jump,
  input  logic        stop,
  output ibus_req_t   ireq,
  input  ibus_resp_t  iresp,
  output fetch_data_t dataF,
  output logic        stopf
`ifdef FETCH_STATS_EN
  ,
  output logic [63:0] stat_fetched,
  output logic [63:0] stat_dropped,
  output logic [63:0] stat_stall
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state;
  logic [63:0]   pc;
  logic          halted;
  logic          req_valid;
  logic [63:0]   req_addr;

  logic          redirect;
  logic [63:0]   redirect_pc;
  logic          has_space;
  logic          misaligned;
  logic          push;
  logic          pop;
  fetch_data_t   push_data;
  fetch_data_t   head;
  logic [CW-1:0] count;

  assign redirect    = flushall | branch;
  assign redirect_pc = flushall ? csrpc : jump;
  assign has_space   = count < CW'(DEPTH);
  assign misaligned  = pc[1:0] != 2'b00;
  assign pop         = (count != '0) && !stop;

  // A redirect flushes the FIFO, so nothing may be pushed on that cycle.
  always_comb begin
    push      = 1'b0;
    push_data = '0;
    if (!redirect) begin
      if (state == REQ && iresp.data_ok) begin
        push      = 1'b1;
        push_data = '{valid: 1'b1, instr: iresp.data, pc: pc, error: NOERROR};
      end else if (state == IDLE && !halted && has_space && misaligned) begin
        push      = 1'b1;
        push_data = '{valid: 1'b1, instr: 32'h0, pc: pc, error: INSTR_MISALIGN};
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (redirect),
    .push  (push),
    .din   (push_data),
    .pop   (pop),
    .head  (head),
    .count (count)
  );

  // A response landing on the redirect cycle ends the bus transaction, so the
  // FSM returns to IDLE instead of waiting in DROP for a second data_ok.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      halted    <= 1'b0;
      req_valid <= 1'b0;
      req_addr  <= '0;
    end else if (redirect) begin
      pc     <= redirect_pc;
      halted <= 1'b0;
      if ((state == REQ || state == DROP) && !iresp.data_ok) begin
        state <= DROP;
      end else begin
        state     <= IDLE;
        req_valid <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (!halted && has_space) begin
            if (misaligned) begin
              halted <= 1'b1;
            end else begin
              state     <= REQ;
              req_valid <= 1'b1;
              req_addr  <= pc;
            end
          end
        end
        REQ: begin
          if (iresp.data_ok) begin
            pc        <= pc + 64'(INSTR_BYTES);
            state     <= IDLE;
            req_valid <= 1'b0;
          end
        end
        DROP: begin
          if (iresp.data_ok) begin
            state     <= IDLE;
            req_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          req_valid <= 1'b0;
        end
      endcase
    end
  end

  assign ireq.valid = req_valid;
  assign ireq.addr  = req_addr;
  assign stopf      = (count == '0);

  always_comb begin
    dataF       = head;
    dataF.valid = (count != '0);
  end

`ifdef FETCH_STATS_EN
  logic [63:0] dropped_now;

  always_comb begin
    dropped_now = '0;
    if (redirect) begin
      dropped_now = 64'(count);
    end
    if (req_valid && iresp.data_ok && (state == DROP || redirect)) begin
      dropped_now = dropped_now + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_fetched <= '0;
      stat_dropped <= '0;
      stat_stall   <= '0;
    end else begin
      if (push && push_data.error == NOERROR) begin
        stat_fetched <= sat_add(stat_fetched, 64'd1);
      end
      stat_dropped <= sat_add(stat_dropped, dropped_now);
      if (req_valid && !iresp.data_ok) begin
        stat_stall <= sat_add(stat_stall, 64'd1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a queue-based model of the fetch FIFO is
// compared every cycle, and directed scenarios pin results to literal values.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int          DEPTH     = 4;
  localparam logic [63:0] RST_PC    = 64'h8000_0000;
  localparam logic [31:0] INSTR_KEY = 32'h1357_9BDF;

  typedef struct {
    int          cyc;
    logic [63:0] addr;
  } issue_t;

  logic        clk      = 1'b0;
  logic        reset    = 1'b0;
  logic        flushall = 1'b0;
  logic [63:0] csrpc    = '0;
  logic        branch   = 1'b0;
  logic [63:0] jump     = '0;
  logic        stop     = 1'b0;
  ibus_req_t   ireq;
  ibus_resp_t  iresp;
  fetch_data_t dataF;
  logic        stopf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  int resp_wait = 0;
  int resp_count = 0;
  logic mon_en = 1'b0;

  // Reference model state
  fetch_data_t exp_q[$];
  logic [63:0] m_pc = RST_PC;
  logic        m_halted = 1'b0;
  logic        m_drop = 1'b0;
  logic        prev_valid = 1'b0;
  logic        prev_ok = 1'b0;
  logic [63:0] prev_addr = '0;
  int          prev_sz = 0;

  fetch_data_t pop_log[$];
  issue_t      issue_log[$];

`ifdef FETCH_STATS_EN
  logic [63:0] stat_fetched, stat_dropped, stat_stall;
`endif

  fetch_queue #(
    .DEPTH       (DEPTH),
    .RESET_PC    (RST_PC),
    .INSTR_BYTES (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flushall (flushall),
    .csrpc    (csrpc),
    .branch   (branch),
    .jump     (jump),
    .stop     (stop),
    .ireq     (ireq),
    .iresp    (iresp),
    .dataF    (dataF),
    .stopf    (stopf)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched (stat_fetched),
    .stat_dropped (stat_dropped),
    .stat_stall   (stat_stall)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish (checks %0d errors %0d)", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Memory-like responder: answers each request after lat wait cycles
  initial begin
    iresp = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        iresp.data_ok = 1'b0;
        resp_wait = 0;
      end else if (iresp.data_ok) begin
        iresp.data_ok = 1'b0;
        resp_wait = 0;
      end else if (ireq.valid) begin
        if (resp_wait >= lat) begin
          iresp.data_ok = 1'b1;
          iresp.data = ireq.addr[31:0] ^ INSTR_KEY;
        end else begin
          resp_wait++;
        end
      end
    end
  end

  // Compare DUT against the model, then advance the model to the next edge
  always @(negedge clk) begin : monitor
    int sz;
    if (reset && mon_en) begin
      checkOutput("stopf", stopf, exp_q.size() == 0);
      checkOutput("head_valid", dataF.valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        checkOutput("head_pc", dataF.pc, exp_q[0].pc);
        checkOutput("head_instr", dataF.instr, exp_q[0].instr);
        checkOutput("head_error", dataF.error, exp_q[0].error);
      end
      if (ireq.valid) begin
        if (!prev_valid || prev_ok) begin
          issue_log.push_back('{cyc, ireq.addr});
          checkOutput("issue_addr", ireq.addr, m_pc);
          checkOutput("issue_space", prev_sz < DEPTH, 1);
          checkOutput("issue_allowed", m_halted | m_drop, 0);
        end else begin
          checkOutput("addr_hold", ireq.addr, prev_addr);
        end
      end

      sz = exp_q.size();
      prev_sz = sz;
      prev_valid = ireq.valid;
      prev_ok = iresp.data_ok;
      prev_addr = ireq.addr;
      if (dataF.valid && !stop) pop_log.push_back(dataF);
      if (ireq.valid && iresp.data_ok) resp_count++;

      if (flushall || branch) begin
        exp_q.delete();
        m_pc = flushall ? csrpc : jump;
        m_halted = 1'b0;
        m_drop = ireq.valid && !iresp.data_ok;
      end else begin
        if (sz != 0 && !stop) void'(exp_q.pop_front());
        if (ireq.valid && iresp.data_ok) begin
          if (m_drop) begin
            m_drop = 1'b0;
          end else begin
            exp_q.push_back('{valid: 1'b1, instr: iresp.data, pc: m_pc, error: NOERROR});
            m_pc = m_pc + 64'd4;
          end
        end else if (!ireq.valid && !m_halted && m_pc[1:0] != 2'b00 && sz < DEPTH) begin
          exp_q.push_back('{valid: 1'b1, instr: 32'h0, pc: m_pc, error: INSTR_MISALIGN});
          m_halted = 1'b1;
        end
      end
    end
  end

  task automatic applyReset();
    mon_en = 1'b0;
    reset = 1'b0;
    flushall = 1'b0;
    branch = 1'b0;
    stop = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    exp_q.delete();
    pop_log.delete();
    issue_log.delete();
    m_pc = RST_PC;
    m_halted = 1'b0;
    m_drop = 1'b0;
    prev_valid = 1'b0;
    prev_ok = 1'b0;
    prev_sz = 0;
    resp_count = 0;
    checkOutput("reset_ireq_valid", ireq.valid, 0);
    checkOutput("reset_data_valid", dataF.valid, 0);
    checkOutput("reset_stopf", stopf, 1);
    reset = 1'b1;
    mon_en = 1'b1;
  endtask

  // Holds a redirect for exactly one cycle; returns the cycle it was applied in
  task automatic applyStimulus(input logic f, input logic [63:0] cp, input logic b,
                               input logic [63:0] j, output int at);
    at = cyc;
    flushall = f;
    csrpc = cp;
    branch = b;
    jump = j;
    step(1);
    flushall = 1'b0;
    branch = 1'b0;
  endtask

  task automatic waitIssue(input int after, input string name, input logic [63:0] exp_addr);
    int idx = -1;
    for (int i = 0; i < 200 && idx < 0; i++) begin
      foreach (issue_log[k]) if (idx < 0 && issue_log[k].cyc > after) idx = k;
      if (idx < 0) step(1);
    end
    checkOutput({name, "_found"}, idx >= 0, 1);
    if (idx >= 0) checkOutput(name, issue_log[idx].addr, exp_addr);
  endtask

  initial begin : stimulus
    logic [63:0] seq_pc [5];
    int c;
    int late;
    seq_pc[0] = 64'h8000_0000;
    seq_pc[1] = 64'h8000_0004;
    seq_pc[2] = 64'h8000_0008;
    seq_pc[3] = 64'h8000_000C;
    seq_pc[4] = 64'h8000_0010;

    // Sequential fetch, decode never stalls
    lat = 1;
    applyReset();
    for (int i = 0; i < 200 && pop_log.size() < 5; i++) step(1);
    checkOutput("t1_five_pops", pop_log.size() >= 5, 1);
    if (pop_log.size() >= 5) begin
      for (int k = 0; k < 5; k++) begin
        checkOutput("t1_pc", pop_log[k].pc, seq_pc[k]);
        checkOutput("t1_instr", pop_log[k].instr, seq_pc[k][31:0] ^ INSTR_KEY);
        checkOutput("t1_error", pop_log[k].error, NOERROR);
      end
    end

    // Backpressure fills the FIFO, then drains and resumes
    applyReset();
    stop = 1'b1;
    step(20);
    checkOutput("t2_ireq_idle", ireq.valid, 0);
    checkOutput("t2_responses", resp_count, 4);
    checkOutput("t2_model_depth", exp_q.size(), 4);
    checkOutput("t2_head_pc", dataF.pc, 64'h8000_0000);
    c = cyc;
    stop = 1'b0;
    waitIssue(c, "t2_resume", 64'h8000_0010);
    for (int i = 0; i < 100 && pop_log.size() < 5; i++) step(1);
    checkOutput("t2_five_pops", pop_log.size() >= 5, 1);
    if (pop_log.size() >= 5) begin
      for (int k = 0; k < 5; k++) checkOutput("t2_pc", pop_log[k].pc, seq_pc[k]);
    end

    // Branch while a request is pending: hold, discard, refetch
    lat = 6;
    applyReset();
    stop = 1'b1;
    for (int i = 0; i < 200 && !(ireq.valid && ireq.addr == 64'h8000_0008); i++) step(1);
    checkOutput("t3_req_seen", ireq.valid && ireq.addr == 64'h8000_0008, 1);
    applyStimulus(1'b0, 64'h0, 1'b1, 64'h8000_1000, c);
    checkOutput("t3_flushed", dataF.valid, 0);
    checkOutput("t3_hold_valid", ireq.valid, 1);
    checkOutput("t3_hold_addr", ireq.addr, 64'h8000_0008);
    waitIssue(c, "t3_target", 64'h8000_1000);
    for (int i = 0; i < 100 && !dataF.valid; i++) step(1);
    checkOutput("t3_first_pc", dataF.pc, 64'h8000_1000);

    // flushall beats branch
    lat = 1;
    applyReset();
    step(4);
    applyStimulus(1'b1, 64'h8000_2000, 1'b1, 64'h8000_3000, c);
    waitIssue(c, "t4_flush_wins", 64'h8000_2000);

    // Misaligned redirect target halts fetch until the next redirect
    applyReset();
    stop = 1'b1;
    step(3);
    applyStimulus(1'b0, 64'h0, 1'b1, 64'h8000_0102, c);
    for (int i = 0; i < 50 && !dataF.valid; i++) step(1);
    checkOutput("t5_error", dataF.error, INSTR_MISALIGN);
    checkOutput("t5_pc", dataF.pc, 64'h8000_0102);
    checkOutput("t5_instr", dataF.instr, 32'h0);
    step(10);
    late = 0;
    foreach (issue_log[k]) if (issue_log[k].cyc > c) late++;
    checkOutput("t5_no_request", late, 0);
    checkOutput("t5_ireq_idle", ireq.valid, 0);
    applyStimulus(1'b0, 64'h0, 1'b1, 64'h8000_0200, c);
    waitIssue(c, "t5_resume", 64'h8000_0200);

    // Asynchronous reset in the middle of a request
    lat = 6;
    applyReset();
    stop = 1'b1;
    for (int i = 0; i < 300 && !(exp_q.size() == 3 && ireq.valid); i++) step(1);
    checkOutput("t6_three_held", exp_q.size() == 3 && ireq.valid, 1);
    #1;
    mon_en = 1'b0;
    reset = 1'b0;
    #1;
    checkOutput("t6_async_ireq", ireq.valid, 0);
    checkOutput("t6_async_valid", dataF.valid, 0);
    checkOutput("t6_async_stopf", stopf, 1);
    lat = 1;
    applyReset();
    waitIssue(0, "t6_restart", 64'h8000_0000);

    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Parametrised successor to the single-entry fetch stage. Generates sequential PCs, issues one outstanding ibus request at a time, and buffers returned instructions in a DEPTH-entry FIFO that decode drains under backpressure. Redirects (flushall, branch) cancel queued and in-flight fetches cleanly without violating the ibus hold rule. Address translation is not done here; ireq.addr carries the fetch PC and any translate stage wraps this block.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
RESET_PC, 64'h8000_0000, PC loaded on reset
INSTR_BYTES, 4, PC increment per sequential fetch

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
flushall  in  1  CSR redirect (trap/mret); highest priority
csrpc  in  64  target for flushall
branch  in  1  branch/jump redirect from execute
jump  in  64  target for branch
stop  in  1  decode backpressure; head not consumed while high
ireq  out  ibus_req_t  instruction bus request (valid, addr)
iresp  in  ibus_resp_t  instruction bus response (data, data_ok)
dataF  out  fetch_data_t  FIFO head: valid, instr, pc, error
stopf  out  1  FIFO empty (decode sees a bubble)

Behaviour:
- Reset (reset==0, async): pc=RESET_PC, FIFO empty, count=0, ireq.valid=0, dataF.valid=0, stopf=1, drop=0, halted=0.
- FSM: IDLE, REQ, DROP.
  - IDLE: issue when !halted and count+1 <= DEPTH (space incl. in-flight slot); pc[1:0]!=0 goes to misalign path instead of REQ.
  - REQ: ireq.valid=1, ireq.addr=pc, held stable until iresp.data_ok. On data_ok: push {valid=1, instr=iresp.data[31:0], pc, NOERROR}; pc+=INSTR_BYTES; return to IDLE. ireq.valid may re-assert the next cycle (min 2 cycles/instr).
  - DROP: entered on redirect during REQ; ireq held with old addr; on data_ok discard data, go IDLE, fetch from the redirected pc.
- Misalign: pc[1:0]!=0 in IDLE with space: push {instr=0, pc, INSTR_MISALIGN} with no bus request, set halted. halted clears only on redirect.
- Redirect, same cycle: FIFO cleared (count=0), pc=target, halted=0. flushall beats branch when both are high. In REQ -> DROP; in DROP stay in DROP; in IDLE stay in IDLE. A response arriving on the redirect cycle is discarded.
- Pop: dataF.valid && !stop. Push and pop in the same cycle keep count unchanged. Push never occurs when full, guaranteed by the space check.
- Pointers: log2(DEPTH) bits with natural wrap. count is log2(DEPTH)+1 bits.
- dataF is a combinational view of the head; dataF.valid = (count!=0). stopf = (count==0).
- Reset mid-request: bus abandoned immediately; ireq.valid drops asynchronously.

Optional Feature:
FETCH_STATS_EN: when defined, adds outputs stat_fetched[63:0] (pushes with NOERROR), stat_dropped[63:0] (responses discarded in DROP plus entries cleared by redirect) and stat_stall[63:0] (cycles with ireq.valid && !data_ok). All reset to 0, saturate at all-ones. When undefined, these ports and counters are absent and functionality is identical.

Decomposition:
- pipes package: fetch_data_t (reused), ibus types (reused), new enum fetch_state_t {IDLE, REQ, DROP}.
- common package: FETCH_RESET_PC constant.
- One sub-module: fetch_fifo, a generic DEPTH x fetch_data_t FIFO with push/pop/clear/count, instantiated once.

Test Plan:
- Reset, then 5 responses with data_ok after 1-cycle latency, stop=0 -> dataF.pc = 0x80000000, 0x80000004 ... 0x80000010 in order, instr matching, error=NOERROR.
- stop=1 for 20 cycles, DEPTH=4 -> exactly 4 pushes, then ireq.valid stays 0. stop released -> one pop per cycle, fetch resumes at 0x80000010.
- branch=1, jump=0x80001000 while ireq is pending on 0x80000008 -> addr held until data_ok, that data is discarded, next ireq.addr=0x80001000, FIFO empty on the redirect cycle.
- flushall=1 (csrpc=0x80002000) and branch=1 (jump=0x80003000) in the same cycle -> next fetch addr is 0x80002000.
- jump=0x80000102 -> one entry with error=INSTR_MISALIGN, pc=0x80000102, no ireq; then branch to 0x80000200 resumes fetching.
- reset pulled low while in REQ with FIFO holding 3 entries -> same cycle: ireq.valid=0, dataF.valid=0. After release, first ireq.addr=0x80000000.
